// File: rtl/nes_bus_pkg.sv
// -----------------------------------------------------------------------------
// nes_bus_pkg
// Shared definitions for the NES CPU-side bus arbiter (nes_bus_arb) and its
// master-select mux (nes_bus_mux).
//   bus_state_t   : arbiter FSM states
//   bus_sel_t     : which master drives the shared bus
//   OAM_DMA_LEN   : length of one sprite OAM DMA in bus cycles
//   MAX_WR_RUN    : longest run of consecutive 6502 writes (RMW / IRQ push)
//   state_to_sel(): default bus owner for each FSM state
// -----------------------------------------------------------------------------
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITRD,
        HALT,
        ALIGN,
        GNT,
        REL
    } bus_state_t;

    typedef enum logic [1:0] {
        SEL_CPU,
        SEL_DUMMY,
        SEL_SPR,
        SEL_DMC
    } bus_sel_t;

    localparam int OAM_DMA_LEN = 512;
    localparam int MAX_WR_RUN  = 3;

    // HALT and ALIGN replay the CPU address as a read so the halted 6502
    // never sees a write it did not issue.
    function automatic bus_sel_t state_to_sel(input bus_state_t st);
        case (st)
            HALT, ALIGN: return SEL_DUMMY;
            GNT:         return SEL_SPR;
            default:     return SEL_CPU;
        endcase
    endfunction

endpackage

// File: rtl/nes_bus_mux.sv
// -----------------------------------------------------------------------------
// nes_bus_mux
// Combinational master select for the shared CPU bus plus read-data fan-out.
// The select comes only from arbiter state registers, so the bus switches
// cleanly on clock edges and never follows a raw request line.
// Ports:
//   i_sel                      bus owner select (bus_sel_t)
//   i_cpu_addr/wn/wdata        6502 address, write_n, write data
//   i_spr_addr/wn/wdata        sprite DMA address, write_n, write data
//   i_dmc_addr                 DMC sample-fetch address (read only)
//   i_bus_rdata                shared bus read data
//   o_bus_addr/wn/wdata        shared bus outputs
//   o_cpu_rdata, o_spr_rdata   read data copies, qualified by each consumer
// -----------------------------------------------------------------------------
module nes_bus_mux
    import nes_bus_pkg::*;
(
    input  bus_sel_t    i_sel,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    input  logic [15:0] i_spr_addr,
    input  logic        i_spr_wn,
    input  logic [7:0]  i_spr_wdata,
    input  logic [15:0] i_dmc_addr,
    input  logic [7:0]  i_bus_rdata,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic [7:0]  o_spr_rdata
);

    always_comb begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wn    = i_cpu_wn;
        o_bus_wdata = i_cpu_wdata;
        case (i_sel)
            SEL_DUMMY: o_bus_wn = 1'b1;
            SEL_SPR: begin
                o_bus_addr  = i_spr_addr;
                o_bus_wn    = i_spr_wn;
                o_bus_wdata = i_spr_wdata;
            end
            SEL_DMC: begin
                o_bus_addr = i_dmc_addr;
                o_bus_wn   = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_cpu_rdata = i_bus_rdata;
    assign o_spr_rdata = i_bus_rdata;

endmodule

// File: rtl/nes_bus_arb.sv
// -----------------------------------------------------------------------------
// nes_bus_arb
// Arbitrates the NES CPU bus between the 6502 and the PPU OAM-DMA master.
// The CPU is stalled through RDY (only possible on a read cycle), each DMA
// grant starts on an even ("get") cycle, and a grant watchdog force-releases
// the bus after P_MAX_GNT cycles, setting the sticky o_gnt_err flag.
// Optional feature macro: NES_DMC_DMA_EN adds a DMC sample-fetch master
// (i_dmc_req, i_dmc_addr, o_dmc_gnt, o_dmc_rdata) that wins in IDLE and can
// steal one even cycle out of a running sprite DMA.
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_cpu_*, o_cpu_rdy/rdata      6502 side
//   i_spr_req/*, o_spr_gnt/rdata  sprite DMA side
//   o_bus_*, i_bus_rdata          shared bus
//   o_gnt_err                     sticky watchdog flag
// -----------------------------------------------------------------------------
module nes_bus_arb
    import nes_bus_pkg::*;
#(
    parameter int P_MAX_GNT = 600,
    parameter int P_CNT_W   = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_rdy,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_spr_req,
    output logic        o_spr_gnt,
    input  logic [15:0] i_spr_addr,
    input  logic        i_spr_wn,
    input  logic [7:0]  i_spr_wdata,
    output logic [7:0]  o_spr_rdata,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
`ifdef NES_DMC_DMA_EN
    input  logic        i_dmc_req,
    input  logic [15:0] i_dmc_addr,
    output logic        o_dmc_gnt,
    output logic [7:0]  o_dmc_rdata,
`endif
    output logic        o_gnt_err
);

    bus_state_t         r_state;
    logic               r_par;
    logic [P_CNT_W-1:0] r_cnt;
    logic [1:0]         r_wr_cnt;
    logic               r_cpu_rdy;
    logic               r_spr_gnt;
    logic               r_gnt_err;

    logic               w_new_req;   // any master asking while IDLE
    logic               w_req;       // request of the master being served
    logic [15:0]        w_dmc_addr;
    bus_sel_t           w_sel;

`ifdef NES_DMC_DMA_EN
    logic r_dmc_own;   // the pending/active grant belongs to DMC
    logic r_dmc_gnt;
    logic r_steal;     // current GNT cycle was stolen from sprite DMA

    assign w_new_req   = i_dmc_req | i_spr_req;
    assign w_req       = r_dmc_own ? i_dmc_req : i_spr_req;
    assign w_dmc_addr  = i_dmc_addr;
    assign o_dmc_gnt   = r_dmc_gnt;
    assign o_dmc_rdata = i_bus_rdata;

    always_comb begin
        w_sel = state_to_sel(r_state);
        if (r_state == GNT && (r_dmc_own || r_steal))
            w_sel = SEL_DMC;
    end
`else
    assign w_new_req  = i_spr_req;
    assign w_req      = i_spr_req;
    assign w_dmc_addr = '0;
    assign w_sel      = state_to_sel(r_state);
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= IDLE;
            r_par     <= 1'b0;
            r_cnt     <= '0;
            r_wr_cnt  <= '0;
            r_cpu_rdy <= 1'b1;
            r_spr_gnt <= 1'b0;
            r_gnt_err <= 1'b0;
`ifdef NES_DMC_DMA_EN
            r_dmc_own <= 1'b0;
            r_dmc_gnt <= 1'b0;
            r_steal   <= 1'b0;
`endif
        end else begin
            r_par <= ~r_par;
            case (r_state)
                IDLE: begin
                    // The IDLE cycle itself is the first write of a run.
                    r_wr_cnt <= 2'd1;
                    if (w_new_req) begin
`ifdef NES_DMC_DMA_EN
                        r_dmc_own <= i_dmc_req;
`endif
                        if (i_cpu_wn) begin
                            r_state   <= HALT;
                            r_cpu_rdy <= 1'b0;
                        end else begin
                            r_state <= WAITRD;
                        end
                    end
                end
                WAITRD: begin
                    // A 6502 never writes more than MAX_WR_RUN times in a
                    // row; a longer run is treated as a read so DMA cannot
                    // be starved by a stuck write line.
                    if (!w_req) begin
                        r_state <= REL;
                    end else if (i_cpu_wn || r_wr_cnt == 2'(MAX_WR_RUN)) begin
                        r_state   <= HALT;
                        r_cpu_rdy <= 1'b0;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 2'd1;
                    end
                end
                HALT, ALIGN: begin
                    if (!w_req) begin
                        r_state <= REL;
                    end else if (r_state == HALT && r_par) begin
                        r_state <= ALIGN;
                    end else begin
                        r_state <= GNT;
`ifdef NES_DMC_DMA_EN
                        if (r_dmc_own) r_dmc_gnt <= 1'b1;
                        else           r_spr_gnt <= 1'b1;
`else
                        r_spr_gnt <= 1'b1;
`endif
                    end
                end
                GNT: begin
`ifdef NES_DMC_DMA_EN
                    if (r_dmc_own) begin
                        r_state   <= REL;
                        r_dmc_gnt <= 1'b0;
                    end else if (r_steal) begin
                        // Counter held across the stolen cycle.
                        r_steal   <= 1'b0;
                        r_dmc_gnt <= 1'b0;
                        if (!i_spr_req) r_state   <= REL;
                        else            r_spr_gnt <= 1'b1;
                    end else
`endif
                    if (!i_spr_req) begin
                        r_state   <= REL;
                        r_spr_gnt <= 1'b0;
                    end else if (r_cnt == P_CNT_W'(P_MAX_GNT - 1)) begin
                        r_state   <= REL;
                        r_spr_gnt <= 1'b0;
                        r_gnt_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + P_CNT_W'(1);
`ifdef NES_DMC_DMA_EN
                        if (i_dmc_req && !r_par) begin
                            r_steal   <= 1'b1;
                            r_spr_gnt <= 1'b0;
                            r_dmc_gnt <= 1'b1;
                        end
`endif
                    end
                end
                REL: begin
                    // Requests seen here are ignored; IDLE samples again.
                    r_state   <= IDLE;
                    r_cpu_rdy <= 1'b1;
                    r_cnt     <= '0;
                    r_spr_gnt <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_cpu_rdy <= 1'b1;
                    r_spr_gnt <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_rdy = r_cpu_rdy;
    assign o_spr_gnt = r_spr_gnt;
    assign o_gnt_err = r_gnt_err;

    nes_bus_mux u_mux (
        .i_sel       (w_sel),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wn    (i_cpu_wn),
        .i_cpu_wdata (i_cpu_wdata),
        .i_spr_addr  (i_spr_addr),
        .i_spr_wn    (i_spr_wn),
        .i_spr_wdata (i_spr_wdata),
        .i_dmc_addr  (w_dmc_addr),
        .i_bus_rdata (i_bus_rdata),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wn    (o_bus_wn),
        .o_bus_wdata (o_bus_wdata),
        .o_cpu_rdata (o_cpu_rdata),
        .o_spr_rdata (o_spr_rdata)
    );

endmodule
